// File: rtl/anode_scan_ctrl_if.sv
// Bundle of the anode scanner's control inputs and display-side outputs.
// The master side (system/bench) drives enable, mask and brightness;
// the slave side (the scanner) drives the anode, digit select and pulses.
interface anode_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic                  en;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [3:0]            brightness;
  logic [NUM_DIGITS-1:0] anode;
  logic [SEL_W-1:0]      digit_sel;
  logic                  slot_start;
  logic                  frame_done;

  modport master (
    output en, digit_mask, brightness,
    input  anode, digit_sel, slot_start, frame_done
  );

  modport slave (
    input  en, digit_mask, brightness,
    output anode, digit_sel, slot_start, frame_done
  );
endinterface

// File: rtl/anode_scan_ctrl.sv
// Multiplexed-display anode scanner: owns the slot prescaler and digit
// counter, drives NUM_DIGITS one-hot anodes with a blank (dead-time)
// interval at the start of each slot, honours a per-digit enable mask and
// exports the current digit index for the segment path.
// Optional feature macro: ANODE_DIM_EN compiles in 4-bit PWM brightness,
// which shortens the post-blank on-time of each slot.
module anode_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV          = 10000,
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  anode_scan_ctrl_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned ON_W  = CNT_W + 1;
  localparam int unsigned SPAN  = DIV - BLANK_CYCLES;

  localparam logic             INACT    = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [SEL_W-1:0] DIG_LAST = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      dig_q, dig_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;

  // On-time of the current slot; at cnt = 0 the freshly computed value is
  // used directly so the first cycle of a slot already sees the new length.
  logic [ON_W-1:0]       on_len_eff;

`ifdef ANODE_DIM_EN
  logic [ON_W-1:0]       on_len_q;
  logic [ON_W-1:0]       on_len_now;
  logic [63:0]           on_prod;

  // Brightness scaling of the post-blank span, evaluated at full width.
  always_comb begin
    on_prod    = 64'(SPAN) * (64'(bus.brightness) + 64'd1);
    on_len_now = ON_W'(on_prod >> 4);
    on_len_eff = (cnt_q == '0) ? on_len_now : on_len_q;
  end

  // Latch the on-time at the first cycle of each slot so mid-slot
  // brightness changes only apply from the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_len_q <= ON_W'(SPAN);
    end else if (cnt_q == '0) begin
      on_len_q <= on_len_now;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign on_len_eff        = ON_W'(SPAN);
`endif

  logic [32:0] rel;
  logic        in_win;

  // Counter advance, window test and next values of all registered outputs.
  always_comb begin
    cnt_d   = '0;
    dig_d   = '0;
    anode_d = {NUM_DIGITS{INACT}};
    sel_d   = '0;
    start_d = 1'b0;
    done_d  = 1'b0;
    // Position relative to the end of the blank interval; bit 32 set means
    // we are still inside the blank interval.
    rel     = {1'b0, 32'(cnt_q)} - 33'(BLANK_CYCLES);
    in_win  = !rel[32] && (rel[31:0] < 32'(on_len_eff));

    if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        dig_d = dig_q;
      end

      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (in_win && (dig_q == SEL_W'(i)) && bus.digit_mask[i]) begin
          anode_d[i] = ~INACT;
        end
      end

      sel_d   = dig_q;
      start_d = (cnt_q == '0);
      done_d  = (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);
    end
  end

  // State and output registers; reset forces all anodes inactive at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      anode_q <= {NUM_DIGITS{INACT}};
      sel_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      anode_q <= anode_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.digit_sel  = sel_q;
  assign bus.slot_start = start_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Bench for anode_scan_ctrl: three instances (4 digits active-low,
// 4 digits active-high, 6 digits with no blank) run in lock-step against a
// slot/frame-time reference model, plus table vectors and corner sequences.
module tb_anode_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_s;
  logic [3:0] mask_a;
  logic [5:0] mask_b;
  logic [3:0] br;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  anode_scan_ctrl_if #(.NUM_DIGITS(4)) ifa ();
  anode_scan_ctrl_if #(.NUM_DIGITS(4)) ifc ();
  anode_scan_ctrl_if #(.NUM_DIGITS(6)) ifb ();

  assign ifa.en = en_s;  assign ifa.digit_mask = mask_a;  assign ifa.brightness = br;
  assign ifc.en = en_s;  assign ifc.digit_mask = mask_a;  assign ifc.brightness = br;
  assign ifb.en = en_s;  assign ifb.digit_mask = mask_b;  assign ifb.brightness = br;

  anode_scan_ctrl #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  anode_scan_ctrl #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  anode_scan_ctrl #(.NUM_DIGITS(6), .DIV(4), .BLANK_CYCLES(0), .ACTIVE_LOW(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct {
    int an;
    int sel;
    int ss;
    int fd;
  } exp_t;

  typedef struct {
    int         edge_no;
    logic [3:0] an_a;
    logic [3:0] an_c;
    int         sel;
    logic       ss;
    logic       fd;
  } vec_t;

  // Model state per instance: enabled-cycle time t and latched on-time.
  int   t_m   [3];
  int   onl_m [3];
  exp_t em    [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  function automatic int on_time(input int div, input int blank, input logic [3:0] b);
`ifdef ANODE_DIM_EN
    return ((div - blank) * (int'(b) + 1)) >> 4;
`else
    return div - blank;
`endif
  endfunction

  // Reference: position in slot and digit follow from elapsed enabled time.
  task automatic model(input int nd, input int div, input int blank, input bit al,
                       input logic en_i, input logic [7:0] mask, input logic [3:0] b,
                       input int t_in, input int onl_in,
                       output int t_out, output int onl_out, output exp_t e);
    int pos, d, onehot, full;
    full    = (1 << nd) - 1;
    onl_out = onl_in;
    if (!en_i) begin
      e.an  = al ? full : 0;
      e.sel = 0;  e.ss = 0;  e.fd = 0;
      t_out = 0;
    end else begin
      pos = t_in % div;
      d   = (t_in / div) % nd;
      if (pos == 0) onl_out = on_time(div, blank, b);
      onehot = (mask[d] && pos >= blank && pos < blank + onl_out) ? (1 << d) : 0;
      e.an  = al ? (full ^ onehot) : onehot;
      e.sel = d;
      e.ss  = (pos == 0) ? 1 : 0;
      e.fd  = (pos == div - 1 && d == nd - 1) ? 1 : 0;
      t_out = t_in + 1;
    end
  endtask

  task automatic compare_model();
    chk("a_anode", 32'(ifa.anode),      em[0].an);
    chk("a_sel",   32'(ifa.digit_sel),  em[0].sel);
    chk("a_start", 32'(ifa.slot_start), em[0].ss);
    chk("a_done",  32'(ifa.frame_done), em[0].fd);
    chk("c_anode", 32'(ifc.anode),      em[1].an);
    chk("c_sel",   32'(ifc.digit_sel),  em[1].sel);
    chk("c_start", 32'(ifc.slot_start), em[1].ss);
    chk("c_done",  32'(ifc.frame_done), em[1].fd);
    chk("b_anode", 32'(ifb.anode),      em[2].an);
    chk("b_sel",   32'(ifb.digit_sel),  em[2].sel);
    chk("b_start", 32'(ifb.slot_start), em[2].ss);
    chk("b_done",  32'(ifb.frame_done), em[2].fd);
  endtask

  task automatic tick();
    @(posedge clk);
    model(4, 8, 2, 1'b1, en_s, {4'b0, mask_a}, br, t_m[0], onl_m[0], t_m[0], onl_m[0], em[0]);
    model(4, 8, 2, 1'b0, en_s, {4'b0, mask_a}, br, t_m[1], onl_m[1], t_m[1], onl_m[1], em[1]);
    model(6, 4, 0, 1'b1, en_s, {2'b0, mask_b}, br, t_m[2], onl_m[2], t_m[2], onl_m[2], em[2]);
    #1;
    edge_n++;
    compare_model();
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Asynchronous reset mid-slot: outputs must settle before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    t_m   = '{0, 0, 0};
    onl_m = '{6, 6, 4};
    #1;
    chk("rst_anode_a", 32'(ifa.anode),      32'hF);
    chk("rst_anode_c", 32'(ifc.anode),      32'h0);
    chk("rst_anode_b", 32'(ifb.anode),      32'h3F);
    chk("rst_sel_a",   32'(ifa.digit_sel),  0);
    chk("rst_start_a", 32'(ifa.slot_start), 0);
    chk("rst_done_a",  32'(ifa.frame_done), 0);
    chk("rst_sel_b",   32'(ifb.digit_sel),  0);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  vec_t tbl[14];
  int   bad;
  int   fd_edges[$];

  initial begin
    tbl[0]  = '{1,  4'b1111, 4'b0000, 0, 1'b1, 1'b0};
    tbl[1]  = '{2,  4'b1111, 4'b0000, 0, 1'b0, 1'b0};
    tbl[2]  = '{3,  4'b1110, 4'b0001, 0, 1'b0, 1'b0};
    tbl[3]  = '{8,  4'b1110, 4'b0001, 0, 1'b0, 1'b0};
    tbl[4]  = '{9,  4'b1111, 4'b0000, 1, 1'b1, 1'b0};
    tbl[5]  = '{10, 4'b1111, 4'b0000, 1, 1'b0, 1'b0};
    tbl[6]  = '{11, 4'b1101, 4'b0010, 1, 1'b0, 1'b0};
    tbl[7]  = '{16, 4'b1101, 4'b0010, 1, 1'b0, 1'b0};
    tbl[8]  = '{17, 4'b1111, 4'b0000, 2, 1'b1, 1'b0};
    tbl[9]  = '{19, 4'b1011, 4'b0100, 2, 1'b0, 1'b0};
    tbl[10] = '{25, 4'b1111, 4'b0000, 3, 1'b1, 1'b0};
    tbl[11] = '{27, 4'b0111, 4'b1000, 3, 1'b0, 1'b0};
    tbl[12] = '{32, 4'b0111, 4'b1000, 3, 1'b0, 1'b1};
    tbl[13] = '{33, 4'b1111, 4'b0000, 0, 1'b1, 1'b0};

    rst_n  = 1'b1;
    en_s   = 1'b1;
    mask_a = 4'b1111;
    mask_b = 6'b111111;
    br     = 4'd15;
    #1;

    // Baseline scan from the vector table.
    do_reset();
    foreach (tbl[i]) begin
      tick_to(tbl[i].edge_no);
      chk("tbl_anode_a", 32'(ifa.anode),      32'(tbl[i].an_a));
      chk("tbl_anode_c", 32'(ifc.anode),      32'(tbl[i].an_c));
      chk("tbl_sel",     32'(ifa.digit_sel),  32'(tbl[i].sel));
      chk("tbl_start",   32'(ifa.slot_start), 32'(tbl[i].ss));
      chk("tbl_done",    32'(ifa.frame_done), 32'(tbl[i].fd));
    end

    // Six-digit wrap: index stays within 0..5, frame pulse every 24 cycles.
    do_reset();
    bad = 0;
    fd_edges.delete();
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (ifb.digit_sel > 3'd5) bad++;
      if (ifb.frame_done) fd_edges.push_back(edge_n);
      if (k == 21) chk("wrap_sel5", 32'(ifb.digit_sel), 5);
      if (k == 25) chk("wrap_sel0", 32'(ifb.digit_sel), 0);
    end
    chk("wrap_range", bad, 0);
    chk("wrap_fd_cnt", fd_edges.size(), 2);
    if (fd_edges.size() == 2) begin
      chk("wrap_fd_1", fd_edges[0], 24);
      chk("wrap_fd_2", fd_edges[1], 48);
    end

    // Masked digit 2: its slot elapses with the anode held inactive.
    do_reset();
    mask_a = 4'b1011;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k >= 17 && k <= 24) begin
        chk("mask_anode", 32'(ifa.anode),     32'hF);
        chk("mask_sel",   32'(ifa.digit_sel), 2);
      end
      if (k == 27) chk("mask_other", 32'(ifa.anode), 32'b0111);
    end
    mask_a = 4'b1111;

    // Enable dropped at cnt = 5 of digit 2, then raised again.
    do_reset();
    tick_to(21);
    en_s = 1'b0;
    tick();
    chk("endrop_anode", 32'(ifa.anode),      32'hF);
    chk("endrop_sel",   32'(ifa.digit_sel),  0);
    chk("endrop_start", 32'(ifa.slot_start), 0);
    en_s = 1'b1;
    tick();
    chk("reen_start", 32'(ifa.slot_start), 1);
    chk("reen_sel",   32'(ifa.digit_sel),  0);
    chk("reen_blank", 32'(ifa.anode),      32'hF);
    tick();
    chk("reen_blank2", 32'(ifa.anode), 32'hF);
    tick();
    chk("reen_on", 32'(ifa.anode), 32'b1110);

`ifdef ANODE_DIM_EN
    // PWM: brightness 7 gives 3 on-cycles, 0 gives none, 15 the full span.
    do_reset();
    br = 4'd7;
    for (int k = 1; k <= 24; k++) begin
      if (k == 9)  br = 4'd0;
      if (k == 17) br = 4'd15;
      tick();
      if (k <= 8)
        chk("dim7", 32'(ifa.anode), (k >= 3 && k <= 5) ? 32'b1110 : 32'b1111);
      else if (k <= 16)
        chk("dim0", 32'(ifa.anode), 32'b1111);
      else
        chk("dim15", 32'(ifa.anode), (k >= 19) ? 32'b1011 : 32'b1111);
    end
    // Brightness change at cnt = 3 leaves the running slot unchanged.
    do_reset();
    br = 4'd15;
    tick_to(3);
    br = 4'd0;
    for (int k = 4; k <= 16; k++) begin
      tick();
      chk("dim_mid", 32'(ifa.anode), (k <= 8) ? 32'b1110 : 32'b1111);
    end
    br = 4'd15;
`endif

    // Randomized run against the reference model, with occasional resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en_s = ($urandom_range(15) != 0);
      if ($urandom_range(7) == 0) mask_a = 4'($urandom);
      if ($urandom_range(7) == 0) mask_b = 6'($urandom);
      br = 4'($urandom);
      if ($urandom_range(499) == 0) begin
        #2;
        do_reset();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/anode_scan_ctrl.md
# anode_scan_ctrl

Parametrised multiplexed-display anode scanner and the generational successor to the fixed 4-digit anode decoder. It owns its own refresh prescaler and digit counter, and drives NUM_DIGITS one-hot anodes with a programmable dead-time between digits to suppress ghosting. It also applies a per-digit enable mask and optional PWM brightness. It sits between the system clock and the display pins, and exports `digit_sel` so the segment/BCD path selects the matching digit data.

## Interface
- `NUM_DIGITS`, 4: number of digits/anodes; must be ≥2; non-power-of-two allowed.
- `DIV`, 10000: clock cycles per digit slot (10 kHz slot rate at 100 MHz); must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 100: dead-time at the start of each slot during which all anodes are inactive; may be 0.
- `ACTIVE_LOW`, 1: 1 means an active anode is driven 0 and an inactive anode 1; 0 inverts this.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable.
- `digit_mask` in NUM_DIGITS: bit i = 0 keeps anode i inactive; its slot time is still consumed.
- `brightness` in 4: PWM level 0–15; used only with `ANODE_DIM_EN`.
- `anode` out NUM_DIGITS: registered anode drive.
- `digit_sel` out SEL_W = $clog2(NUM_DIGITS): index of the current slot's digit (registered).
- `slot_start` out 1: one-cycle pulse at the first cycle of every slot.
- `frame_done` out 1: one-cycle pulse at the last cycle of the slot for digit NUM_DIGITS-1.

## Operation
- Internal state: slot counter `cnt` (0..DIV-1, width $clog2(DIV)), digit counter (0..NUM_DIGITS-1), and latched on-time `on_len`.
- Counter behaviour while `en` = 1:
  - `cnt` increments every cycle.
  - At `cnt` = DIV-1, `cnt` → 0 and the digit counter advances.
  - The digit counter wraps NUM_DIGITS-1 → 0; for example, with 6 digits it wraps 5 → 0, never reaching 6 or 7.
- `en` = 0: `cnt` and the digit counter are synchronously cleared to 0. All anodes go inactive, `slot_start` = `frame_done` = 0, and `digit_sel` = 0.
- On re-enable, scanning restarts at digit 0 with a full blank interval.
- Anode i is active iff all of the following hold:
  - `en` = 1;
  - the digit counter equals i;
  - `digit_mask[i]` = 1;
  - BLANK_CYCLES ≤ `cnt` < BLANK_CYCLES + `on_len`.
- At most one anode is active at any time; all others are inactive.
- `on_len`:
  - Without the macro: `on_len` = DIV - BLANK_CYCLES.
  - With the macro: `on_len` = ((DIV - BLANK_CYCLES) × (`brightness` + 1)) >> 4, using a full-width intermediate with no overflow.
  - Latched when `cnt` = 0, so a change to `brightness` mid-slot takes effect at the next slot.
- `digit_mask` is not latched; a change takes effect on the next clock edge.
- `slot_start` is asserted for `cnt` = 0 (with `en` = 1).
- `frame_done` is asserted for `cnt` = DIV-1 with digit counter = NUM_DIGITS-1 (with `en` = 1).

## Timing
- All outputs are registered. An output after edge n reflects `cnt`, digit counter, `en`, and mask as sampled at edge n, giving one cycle of latency.
- Reset values, applied asynchronously while `rst_n` = 0:
  - `anode` = all inactive (all 1s when ACTIVE_LOW = 1);
  - `digit_sel` = 0, `slot_start` = 0, `frame_done` = 0;
  - `cnt` = 0, digit counter = 0, `on_len` = DIV - BLANK_CYCLES.
- Reset asserted mid-slot drives the outputs to their reset values immediately, without waiting for a clock edge.
- After `rst_n` is released with `en` = 1, edge 1 starts slot 0.
- Slot period is exactly DIV cycles; frame period is NUM_DIGITS × DIV cycles.
- `digit_sel` changes on the same edge as `slot_start` rises, so downstream segment data can switch during the blank interval.

## Configuration
- `ANODE_DIM_EN`
  - Defined: `brightness` PWM is compiled in, with `on_len` as computed above. Note that `brightness` = 0 yields `on_len` = 0 whenever DIV - BLANK_CYCLES < 16.
  - Undefined: the `brightness` port remains present but is ignored, the multiplier/latch logic is absent, and the anode is active for the whole post-blank portion of the slot.

## Test plan
- Baseline scan:
  - Setup: NUM_DIGITS=4, DIV=8, BLANK=2, ACTIVE_LOW=1, mask=4'b1111, `en`=1 after reset.
  - `anode` = 4'b1110 after edges 3–8 and 4'b1111 after edges 1–2 and 9–10.
  - `anode` = 4'b1101 after edges 11–16.
  - `slot_start` is high after edges 1, 9, 17, 25; `frame_done` is high after edge 32; `digit_sel` = 0, 1, 2, 3, 0.
- Mask: with mask=4'b1011, `anode` stays 4'b1111 for the whole digit-2 slot (edges 17–24) while `digit_sel` = 2; the other digits are unchanged.
- Wrap with non-power-of-two digit count: NUM_DIGITS=6, DIV=4, BLANK=0 → `digit_sel` cycles 0..5, then 0, and never shows 6 or 7; `frame_done` pulses every 24 cycles.
- Enable and reset mid-slot:
  - Drop `en` at `cnt`=5 of digit 2 → `anode` all 1s next edge and `digit_sel` = 0; re-raise `en` → slot 0 restarts with 2 blank cycles.
  - Assert `rst_n`=0 asynchronously mid-slot → outputs reach their reset values before the next edge.
- With `ANODE_DIM_EN` (DIV=8, BLANK=2):
  - `brightness`=7 → anode active for `cnt` 2–4 (3 cycles).
  - `brightness`=15 → active for `cnt` 2–7.
  - `brightness`=0 → never active.
  - Changing `brightness` at `cnt`=3 leaves the current slot unchanged.
- ACTIVE_LOW=0: same stimulus as the baseline scan → `anode` = 4'b0001 after edges 3–8, and 4'b0000 during the blank interval and during reset.
